// File: rtl/lpcm_tdm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lpcm_tdm_scheduler
// Brief    : Frame-based TDM scheduler sharing one LPCM bus among NUM_CH
//            sample sources. Optional checks: define LPCM_TDM_SCHED_ASSERT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lpcm_tdm_scheduler #(
   parameter int NUM_CH   = 4,
   parameter int CH_W     = $clog2(NUM_CH),
   parameter int PERIOD_W = 16
) (
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   cfg_start,
   input  logic [PERIOD_W-1:0]    cfg_period,
   input  logic [NUM_CH-1:0]      cfg_ch_mask,
   input  logic [NUM_CH-1:0]      in_valid,
   input  logic [NUM_CH*32-1:0]   in_data,
   output logic [NUM_CH-1:0]      in_ready,
   output logic                   out_en,
   output logic [31:0]            out_data,
   output logic [CH_W-1:0]        out_ch,
   output logic                   frame_start,
   output logic                   busy,
   output logic [NUM_CH-1:0]      underrun,
   input  logic                   underrun_clr
);

   localparam logic [0:0]          c_IDLE   = 1'b0;
   localparam logic [0:0]          c_RUN    = 1'b1;
   localparam logic [PERIOD_W-1:0] c_NCH    = PERIOD_W'(NUM_CH);
   localparam logic [PERIOD_W-1:0] c_ONE    = PERIOD_W'(1);
   localparam logic [NUM_CH-1:0]   c_ONEHOT = NUM_CH'(1);

   logic [0:0]          r_state;
   logic [0:0]          w_state_nxt;
   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W-1:0] w_cnt_nxt;
   logic [PERIOD_W-1:0] r_period_l;
   logic [PERIOD_W-1:0] w_period;
   logic [PERIOD_W-1:0] w_peff;
   logic [NUM_CH-1:0]   r_mask_l;
   logic [NUM_CH-1:0]   w_mask;
   logic [NUM_CH-1:0]   w_onehot;
   logic [NUM_CH-1:0]   w_ready;
   logic [CH_W-1:0]     w_idx;
   logic                w_run;
   logic                w_frame0;
   logic                w_slot;
   logic                w_wrap;
   logic                r_out_en;
   logic [31:0]         r_out_data;
   logic [CH_W-1:0]     r_out_ch;
   logic [NUM_CH-1:0]   r_underrun;
   logic [31:0]         w_ch_data [NUM_CH];

   assign w_run    = (r_state == c_RUN);
   assign w_frame0 = w_run && (r_cnt == '0);

   // On the first frame cycle the live config is used so it applies to the whole frame.
   assign w_period = w_frame0 ? cfg_period  : r_period_l;
   assign w_mask   = w_frame0 ? cfg_ch_mask : r_mask_l;
   assign w_peff   = (w_period < c_NCH) ? c_NCH : w_period;
   assign w_wrap   = (r_cnt == (w_peff - c_ONE));
   assign w_slot   = w_run && (r_cnt < c_NCH);
   assign w_idx    = r_cnt[CH_W-1:0];
   assign w_onehot = c_ONEHOT << w_idx;

   // State register
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_state <= c_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      case (r_state)
         c_IDLE: begin
            if (cfg_start) w_state_nxt = c_RUN;
         end
         c_RUN: begin
            if (w_wrap) begin
               if (!cfg_start) w_state_nxt = c_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + c_ONE;
            end
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy        = w_run;
      frame_start = w_frame0;
      w_ready     = w_slot ? (w_onehot & w_mask) : '0;
   end

   assign in_ready = w_ready;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_period_l <= '0;
         r_mask_l   <= '0;
      end else if (w_frame0) begin
         r_period_l <= cfg_period;
         r_mask_l   <= cfg_ch_mask;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_out_en   <= 1'b0;
         r_out_ch   <= '0;
         r_out_data <= '0;
      end else if (w_slot && w_mask[w_idx]) begin
         r_out_en   <= 1'b1;
         r_out_ch   <= w_idx;
         r_out_data <= in_valid[w_idx] ? w_ch_data[w_idx] : 32'h0;
      end else begin
         r_out_en   <= 1'b0;
         r_out_ch   <= '0;
         r_out_data <= '0;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign w_ch_data[gi] = in_data[32*gi +: 32];

         // A new underrun wins over a simultaneous clear so no event is lost.
         always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
               r_underrun[gi] <= 1'b0;
            end else if (w_ready[gi] && !in_valid[gi]) begin
               r_underrun[gi] <= 1'b1;
            end else if (underrun_clr) begin
               r_underrun[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   assign out_en   = r_out_en;
   assign out_data = r_out_data;
   assign out_ch   = r_out_ch;
   assign underrun = r_underrun;

`ifdef LPCM_TDM_SCHED_ASSERT_EN
   a_no_x_data : assert property (@(posedge clk) disable iff (!resetb)
      out_en |-> ((^out_data) !== 1'bx));
   a_onehot_ready : assert property (@(posedge clk) disable iff (!resetb)
      $onehot0(in_ready));
   a_masked_out : assert property (@(posedge clk) disable iff (!resetb)
      out_en |-> r_mask_l[out_ch]);
   c_stop_mid_frame : cover property (@(posedge clk) disable iff (!resetb)
      busy && !frame_start && !cfg_start);

   generate
      for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_cov
         c_underrun : cover property (@(posedge clk) disable iff (!resetb)
            in_ready[gc] && !in_valid[gc]);
      end
   endgenerate
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_lpcm_tdm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpcm_tdm_scheduler
// Brief    : Directed self-checking bench for lpcm_tdm_scheduler (NUM_CH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lpcm_tdm_scheduler;

   logic          clk;
   logic          resetb;
   logic          cfg_start;
   logic [15:0]   cfg_period;
   logic [3:0]    cfg_ch_mask;
   logic [3:0]    in_valid;
   logic [127:0]  in_data;
   logic [3:0]    in_ready;
   logic          out_en;
   logic [31:0]   out_data;
   logic [1:0]    out_ch;
   logic          frame_start;
   logic          busy;
   logic [3:0]    underrun;
   logic          underrun_clr;

   int checks = 0;
   int errors = 0;

   lpcm_tdm_scheduler #(.NUM_CH(4), .CH_W(2), .PERIOD_W(16)) dut (
      .clk          (clk),
      .resetb       (resetb),
      .cfg_start    (cfg_start),
      .cfg_period   (cfg_period),
      .cfg_ch_mask  (cfg_ch_mask),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_en       (out_en),
      .out_data     (out_data),
      .out_ch       (out_ch),
      .frame_start  (frame_start),
      .busy         (busy),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_idle();
      int n;
      n = 0;
      cfg_start = 1'b0;
      while (busy === 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_timeout: busy got %0b expected 0", busy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %0b expected 0", frame_start); end
      checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b expected 0", out_en); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", out_data); end
      checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", out_ch); end
      checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %0h expected 0", in_ready); end
      checks++; if (underrun !== 4'h0) begin errors++; $display("FAIL reset_underrun: got %0h expected 0", underrun); end
      resetb = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
      checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL idle_ready: got %0h expected 0", in_ready); end
   endtask

   task automatic test_full_frame();
      logic [3:0]  e_rdy;
      logic        e_en;
      logic [1:0]  e_ch;
      logic [31:0] e_data;
      int c;
      cfg_period = 16'd8; cfg_ch_mask = 4'hF; in_valid = 4'hF; cfg_start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         c      = k % 8;
         e_rdy  = (c < 4) ? (4'b0001 << c) : 4'h0;
         e_en   = (c >= 1 && c <= 4);
         e_ch   = e_en ? 2'(c - 1) : 2'd0;
         e_data = e_en ? (32'hA0 + 32'(c - 1)) : 32'h0;
         checks++; if (frame_start !== (c == 0)) begin errors++; $display("FAIL full_fs k=%0d: got %0b expected %0b", k, frame_start, (c == 0)); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy k=%0d: got %0b expected 1", k, busy); end
         checks++; if (in_ready !== e_rdy) begin errors++; $display("FAIL full_ready k=%0d: got %0h expected %0h", k, in_ready, e_rdy); end
         checks++; if (out_en !== e_en) begin errors++; $display("FAIL full_en k=%0d: got %0b expected %0b", k, out_en, e_en); end
         checks++; if (out_ch !== e_ch) begin errors++; $display("FAIL full_ch k=%0d: got %0d expected %0d", k, out_ch, e_ch); end
         checks++; if (out_data !== e_data) begin errors++; $display("FAIL full_data k=%0d: got %0h expected %0h", k, out_data, e_data); end
         @(negedge clk);
      end
      wait_idle();
      checks++; if (underrun !== 4'h0) begin errors++; $display("FAIL full_underrun: got %0h expected 0", underrun); end
   endtask

   task automatic test_mask();
      logic [3:0]  e_rdy;
      logic        e_en;
      logic [1:0]  e_ch;
      logic [31:0] e_data;
      cfg_ch_mask = 4'b1010; cfg_start = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 8; c++) begin
         e_rdy  = (c == 1) ? 4'b0010 : (c == 3) ? 4'b1000 : 4'b0000;
         e_en   = (c == 2 || c == 4);
         e_ch   = (c == 2) ? 2'd1 : (c == 4) ? 2'd3 : 2'd0;
         e_data = (c == 2) ? 32'hA1 : (c == 4) ? 32'hA3 : 32'h0;
         checks++; if (in_ready !== e_rdy) begin errors++; $display("FAIL mask_ready c=%0d: got %0h expected %0h", c, in_ready, e_rdy); end
         checks++; if (out_en !== e_en) begin errors++; $display("FAIL mask_en c=%0d: got %0b expected %0b", c, out_en, e_en); end
         checks++; if (out_ch !== e_ch) begin errors++; $display("FAIL mask_ch c=%0d: got %0d expected %0d", c, out_ch, e_ch); end
         checks++; if (out_data !== e_data) begin errors++; $display("FAIL mask_data c=%0d: got %0h expected %0h", c, out_data, e_data); end
         @(negedge clk);
      end
      wait_idle();
      cfg_ch_mask = 4'hF;
   endtask

   task automatic test_underrun();
      int c;
      int f;
      in_valid = 4'b1011; cfg_start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         c = k % 8;
         f = k / 8;
         if (f == 0 && c == 2) begin
            checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL ur_ready: got %0h expected 4", in_ready); end
            checks++; if (underrun !== 4'h0) begin errors++; $display("FAIL ur_pre: got %0h expected 0", underrun); end
         end
         if (f == 0 && c == 3) begin
            checks++; if (out_en !== 1'b1) begin errors++; $display("FAIL ur_en: got %0b expected 1", out_en); end
            checks++; if (out_ch !== 2'd2) begin errors++; $display("FAIL ur_ch: got %0d expected 2", out_ch); end
            checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL ur_silence: got %0h expected 0", out_data); end
            checks++; if (underrun !== 4'b0100) begin errors++; $display("FAIL ur_flag: got %0h expected 4", underrun); end
         end
         if (f == 0 && c == 4) begin
            checks++; if (out_data !== 32'hA3) begin errors++; $display("FAIL ur_ch3_data: got %0h expected a3", out_data); end
         end
         if (f == 1 && c == 2) underrun_clr = 1'b1;
         if (f == 1 && c == 3) begin
            underrun_clr = 1'b0;
            checks++; if (underrun !== 4'b0100) begin errors++; $display("FAIL ur_set_priority: got %0h expected 4", underrun); end
         end
         if (f == 1 && c == 4) underrun_clr = 1'b1;
         if (f == 1 && c == 5) begin
            underrun_clr = 1'b0;
            checks++; if (underrun !== 4'h0) begin errors++; $display("FAIL ur_clear: got %0h expected 0", underrun); end
         end
         @(negedge clk);
      end
      in_valid = 4'hF;
      wait_idle();
      checks++; if (underrun !== 4'h0) begin errors++; $display("FAIL ur_final: got %0h expected 0", underrun); end
   endtask

   task automatic test_short_period();
      logic [3:0]  e_rdy;
      logic        e_en;
      logic [1:0]  e_ch;
      logic [31:0] e_data;
      int c;
      cfg_period = 16'd2; cfg_start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         c      = k % 4;
         e_rdy  = 4'b0001 << c;
         e_en   = (k >= 1);
         e_ch   = e_en ? 2'((c + 3) % 4) : 2'd0;
         e_data = e_en ? (32'hA0 + 32'((c + 3) % 4)) : 32'h0;
         checks++; if (frame_start !== (c == 0)) begin errors++; $display("FAIL short_fs k=%0d: got %0b expected %0b", k, frame_start, (c == 0)); end
         checks++; if (in_ready !== e_rdy) begin errors++; $display("FAIL short_ready k=%0d: got %0h expected %0h", k, in_ready, e_rdy); end
         checks++; if (out_en !== e_en) begin errors++; $display("FAIL short_en k=%0d: got %0b expected %0b", k, out_en, e_en); end
         checks++; if (out_ch !== e_ch) begin errors++; $display("FAIL short_ch k=%0d: got %0d expected %0d", k, out_ch, e_ch); end
         checks++; if (out_data !== e_data) begin errors++; $display("FAIL short_data k=%0d: got %0h expected %0h", k, out_data, e_data); end
         @(negedge clk);
      end
      wait_idle();
      cfg_period = 16'd8;
   endtask

   task automatic test_stop_mid();
      logic [3:0]  e_rdy;
      logic        e_en;
      logic [31:0] e_data;
      cfg_start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 13; k++) begin
         e_rdy  = (k < 4) ? (4'b0001 << k) : 4'h0;
         e_en   = (k >= 1 && k <= 4);
         e_data = e_en ? (32'hA0 + 32'(k - 1)) : 32'h0;
         checks++; if (busy !== (k < 8)) begin errors++; $display("FAIL stop_busy k=%0d: got %0b expected %0b", k, busy, (k < 8)); end
         checks++; if (in_ready !== e_rdy) begin errors++; $display("FAIL stop_ready k=%0d: got %0h expected %0h", k, in_ready, e_rdy); end
         checks++; if (out_en !== e_en) begin errors++; $display("FAIL stop_en k=%0d: got %0b expected %0b", k, out_en, e_en); end
         checks++; if (out_data !== e_data) begin errors++; $display("FAIL stop_data k=%0d: got %0h expected %0h", k, out_data, e_data); end
         if (k == 1) cfg_start = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      cfg_start = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL rmid_ready: got %0h expected 4", in_ready); end
      checks++; if (out_ch !== 2'd1) begin errors++; $display("FAIL rmid_ch: got %0d expected 1", out_ch); end
      #2 resetb = 1'b0;
      #1;
      checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL rmid_en: got %0b expected 0", out_en); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rmid_data: got %0h expected 0", out_data); end
      checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL rmid_outch: got %0d expected 0", out_ch); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b expected 0", busy); end
      checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL rmid_rdy0: got %0h expected 0", in_ready); end
      @(negedge clk);
      resetb = 1'b1;
      @(negedge clk);
      checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rrel_fs: got %0b expected 1", frame_start); end
      checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rrel_ready: got %0h expected 1", in_ready); end
      @(negedge clk);
      checks++; if (out_en !== 1'b1) begin errors++; $display("FAIL rrel_en: got %0b expected 1", out_en); end
      checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL rrel_ch: got %0d expected 0", out_ch); end
      checks++; if (out_data !== 32'hA0) begin errors++; $display("FAIL rrel_data: got %0h expected a0", out_data); end
      wait_idle();
   endtask

   initial begin
      resetb       = 1'b0;
      cfg_start    = 1'b0;
      cfg_period   = 16'd8;
      cfg_ch_mask  = 4'hF;
      in_valid     = 4'hF;
      in_data      = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      underrun_clr = 1'b0;
      test_reset();
      test_full_frame();
      test_mask();
      test_underrun();
      test_short_period();
      test_stop_mid();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lpcm_tdm_scheduler.md
Name: lpcm_tdm_scheduler

Overview:
- Time-division scheduler sharing one LPCM bus (en/data[31:0]) between NUM_CH sample sources.
- Once per programmable frame period, scans channels 0..NUM_CH-1 in fixed order and grants one sample per enabled channel.
- Drives the registered LPCM output and flags per-channel underruns.
- Sits between per-channel sample producers and the single downstream LPCM consumer.

Parameters:
NUM_CH, 4, number of requesting channels (2..16)
CH_W, $clog2(NUM_CH), width of channel index
PERIOD_W, 16, width of frame period configuration

Ports:
clk  input  1  system clock
resetb  input  1  asynchronous active-low reset
cfg_start  input  1  level; 1 = run frames, 0 = stop at end of current frame
cfg_period  input  PERIOD_W  clock cycles per frame
cfg_ch_mask  input  NUM_CH  per-channel enable, bit i = channel i
in_valid  input  NUM_CH  channel i has a sample
in_data  input  NUM_CH*32  channel i sample at [32*i+31:32*i]
in_ready  output  NUM_CH  grant; transfer when in_valid[i] & in_ready[i]
out_en  output  1  LPCM enable
out_data  output  32  LPCM sample
out_ch  output  CH_W  channel index of current out_data
frame_start  output  1  one-cycle pulse on first cycle of each frame
busy  output  1  1 while in RUN
underrun  output  NUM_CH  sticky flag per channel
underrun_clr  input  1  pulse; clears all underrun flags

Behaviour:
- Reset (async, resetb=0): state IDLE, cnt=0, all outputs 0, latched config 0.
- States:
  - IDLE: cnt=0; in_ready=0. cfg_start=1 -> RUN next cycle with cnt=0.
  - RUN: cnt increments every cycle and wraps from P_eff-1 to 0. At the wrap, cfg_start=0 -> IDLE, else stay in RUN.
- P_eff = max(cfg_period, NUM_CH); cfg_period=0 also gives NUM_CH.
- cfg_period and cfg_ch_mask are latched when cnt=0 in RUN and held for the whole frame. Mid-frame changes take effect next frame.
- frame_start = (state==RUN && cnt==0); busy = (state==RUN). Both combinational from registers.
- Slot: cycles with cnt < NUM_CH; slot channel = cnt. All other cycles are idle gap.
- in_ready[i] = RUN && cnt==i && mask_l[i]. At most one bit set per cycle.
- Output is registered, one cycle after the slot of an enabled channel:
  - out_en=1, out_ch=i.
  - out_data = in_data[i] if in_valid[i] was high in the slot; otherwise 32'h0 (silence), and underrun[i] is set.
  - Masked channels and gap cycles: out_en=0, out_data=0, out_ch=0.
- out_data is never X when out_en=1.
- underrun: set has priority over underrun_clr in the same cycle.
- cfg_start deasserted mid-frame: the remaining slots of the frame still run; the block enters IDLE at the wrap. The final sample appears on out_en the cycle after the last slot.
- Reset mid-frame: everything clears immediately. A pending output sample is lost, no grant is issued, and the producer's sample stays pending.

Optional Feature:
- Macro LPCM_TDM_SCHED_ASSERT_EN.
- When defined, concurrent assertions on posedge clk, disabled while !resetb:
  - out_en implies ^out_data !== 1'bx;
  - $onehot0(in_ready);
  - out_en implies mask_l[out_ch] was set.
- Also adds cover properties for an underrun on each channel and for a stop mid-frame.
- When undefined, no assertion or cover code is compiled; functional behaviour is identical.

Test Plan:
- NUM_CH=4, period=8, mask=4'hF, all valid, data=32'hA0+i -> out_en high for cycles 1-4 of each frame with data A0,A1,A2,A3, out_ch 0..3; gap 4 cycles; frame_start every 8 cycles.
- mask=4'b1010 -> only ch1 and ch3 granted; out_en pulses at frame cycles 2 and 4; in_ready[0], in_ready[2] never high.
- ch2 in_valid=0 -> out_data=0 at ch2's output cycle, underrun=4'b0100. Pulse underrun_clr in the same cycle as a new ch2 underrun -> flag stays 1.
- period=2 (< NUM_CH) -> effective frame 4 cycles, back-to-back out_en, frame_start every 4 cycles.
- cfg_start dropped at cnt=1 -> slots 2,3 still granted, busy falls after wrap, no further in_ready.
- resetb asserted at cnt=2 -> all outputs 0 asynchronously; after release with cfg_start=1, new frame begins at ch0.
